// File: rtl/state_dump_unit_pkg.sv
// Shared types for the end-of-run state dump engine: beat kinds, FSM states and reset polarity.
package state_dump_unit_pkg;

    localparam logic RESET = 1'b0;

    typedef enum logic [1:0] {
        DUMP_REG = 2'd0,
        DUMP_MEM = 2'd1,
        DUMP_CHK = 2'd2
    } dump_kind_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_SEND,
        ST_CHK,
        ST_FIN
    } dump_state_t;

    function automatic int max_width(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/state_dump_unit.sv
// state_dump_unit: streams every register-file entry, then every data-memory word, on a valid/ready port.
// Define DUMP_CHECKSUM_EN to append one modular-sum checksum beat after the last memory word.
module state_dump_unit
    import state_dump_unit_pkg::*;
#(
    parameter int  DATA_ADDRESS_WIDTH          = 6,
    parameter int  CPU_DATA_WIDTH              = 32,
    parameter int  REGISTER_FILE_ADDRESS_WIDTH = 5,
    localparam int IDX_W = max_width(REGISTER_FILE_ADDRESS_WIDTH, DATA_ADDRESS_WIDTH)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    output logic                                   busy,
    output logic                                   done,
    output logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] rf_rd_addr,
    input  logic [CPU_DATA_WIDTH-1:0]              rf_rd_data,
    output logic                                   mem_rd_en,
    output logic [DATA_ADDRESS_WIDTH-1:0]          mem_rd_addr,
    input  logic [CPU_DATA_WIDTH-1:0]              mem_rd_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [CPU_DATA_WIDTH-1:0]              out_data,
    output dump_kind_t                             out_kind,
    output logic [IDX_W-1:0]                       out_index,
    output logic                                   out_last
);

    // One spare bit on the counter keeps the terminal compare clear of wrap-around.
    localparam int               CNT_W    = IDX_W + 1;
    localparam logic [CNT_W-1:0] REG_LAST = CNT_W'((1 << REGISTER_FILE_ADDRESS_WIDTH) - 1);
    localparam logic [CNT_W-1:0] MEM_LAST = CNT_W'((1 << DATA_ADDRESS_WIDTH) - 1);

    dump_state_t               state;
    dump_kind_t                phase;
    logic [CNT_W-1:0]          idx;
    logic                      at_end;
    dump_kind_t                next_phase;
    logic [CNT_W-1:0]          next_idx;
    logic [CPU_DATA_WIDTH-1:0] rd_word;
`ifdef DUMP_CHECKSUM_EN
    logic [CPU_DATA_WIDTH-1:0] acc;
`endif

    always_comb begin
        at_end     = (phase == DUMP_REG) ? (idx == REG_LAST) : (idx == MEM_LAST);
        next_phase = phase;
        next_idx   = idx + CNT_W'(1);
        if (at_end) begin
            next_phase = DUMP_MEM;
            next_idx   = '0;
        end
        rd_word = (phase == DUMP_REG) ? rf_rd_data : mem_rd_data;
    end

    always_ff @(posedge clk) begin
        if (rst == RESET) begin
            state       <= ST_IDLE;
            phase       <= DUMP_REG;
            idx         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rf_rd_addr  <= '0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_kind    <= DUMP_REG;
            out_index   <= '0;
            out_last    <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            acc         <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state       <= ST_READ;
                        busy        <= 1'b1;
                        phase       <= DUMP_REG;
                        idx         <= '0;
                        rf_rd_addr  <= '0;
                        mem_rd_addr <= '0;
                        mem_rd_en   <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
                        acc         <= '0;
`endif
                    end
                end
                ST_READ: begin
                    mem_rd_en <= 1'b0;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    out_data  <= rd_word;
                    out_kind  <= phase;
                    out_index <= idx[IDX_W-1:0];
                    out_valid <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
                    out_last  <= 1'b0;
                    acc       <= acc + rd_word;
`else
                    out_last  <= (phase == DUMP_MEM) && at_end;
`endif
                    state     <= ST_SEND;
                end
                ST_SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if ((phase == DUMP_MEM) && at_end) begin
`ifdef DUMP_CHECKSUM_EN
                            state     <= ST_CHK;
                            out_valid <= 1'b1;
                            out_data  <= acc;
                            out_kind  <= DUMP_CHK;
                            out_index <= '0;
                            out_last  <= 1'b1;
`else
                            state     <= ST_FIN;
                            done      <= 1'b1;
`endif
                        end else begin
                            state       <= ST_READ;
                            phase       <= next_phase;
                            idx         <= next_idx;
                            rf_rd_addr  <= next_idx[REGISTER_FILE_ADDRESS_WIDTH-1:0];
                            mem_rd_addr <= next_idx[DATA_ADDRESS_WIDTH-1:0];
                            mem_rd_en   <= (next_phase == DUMP_MEM);
                        end
                    end
                end
`ifdef DUMP_CHECKSUM_EN
                ST_CHK: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        state     <= ST_FIN;
                        done      <= 1'b1;
                    end
                end
`endif
                ST_FIN: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_state_dump_unit.sv
// Directed-sequence bench for state_dump_unit with randomized memory contents and sink back-pressure.
module tb_state_dump_unit;
    import state_dump_unit_pkg::*;

    localparam int DAW  = 6;
    localparam int CDW  = 32;
    localparam int RFAW = 5;
    localparam int IW   = 6;
    localparam int NREG = 32;
    localparam int NMEM = 64;
`ifdef DUMP_CHECKSUM_EN
    localparam int NB = NREG + NMEM + 1;
`else
    localparam int NB = NREG + NMEM;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic            out_ready = 1'b0;
    logic            busy, done, mem_rd_en, out_valid, out_last;
    logic [RFAW-1:0] rf_rd_addr;
    logic [DAW-1:0]  mem_rd_addr;
    logic [CDW-1:0]  rf_rd_data, mem_rd_data, out_data;
    dump_kind_t      out_kind;
    logic [IW-1:0]   out_index;

    state_dump_unit #(
        .DATA_ADDRESS_WIDTH(DAW),
        .CPU_DATA_WIDTH(CDW),
        .REGISTER_FILE_ADDRESS_WIDTH(RFAW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_kind(out_kind), .out_index(out_index), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // Synchronous-read storage standing in for the core's register file and data memory.
    logic [CDW-1:0] regs[NREG];
    logic [CDW-1:0] mem[NMEM];
    always @(posedge clk) begin
        rf_rd_data <= regs[rf_rd_addr];
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    int checks = 0;
    int failures = 0;

    logic [CDW-1:0] e_data[NB];
    logic [1:0]     e_kind[NB];
    int             e_index[NB];
    logic           e_last[NB];
    logic [CDW-1:0] g_data[NB];
    logic [1:0]     g_kind[NB];
    int             g_index[NB];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected beat list: every register in order, every memory word in order, then the optional sum.
    task automatic build_model();
        logic [CDW-1:0] sum;
        sum = '0;
        for (int i = 0; i < NREG; i++) begin
            e_data[i] = regs[i]; e_kind[i] = 2'd0; e_index[i] = i; e_last[i] = 1'b0;
            sum = sum + regs[i];
        end
        for (int j = 0; j < NMEM; j++) begin
            e_data[NREG+j] = mem[j]; e_kind[NREG+j] = 2'd1; e_index[NREG+j] = j; e_last[NREG+j] = 1'b0;
            sum = sum + mem[j];
        end
`ifdef DUMP_CHECKSUM_EN
        e_data[NB-1] = sum; e_kind[NB-1] = 2'd2; e_index[NB-1] = 0;
`endif
        e_last[NB-1] = 1'b1;
    endtask

    task automatic randomize_state();
        for (int i = 0; i < NREG; i++) regs[i] = $urandom;
        regs[0] = '0;
        for (int j = 0; j < NMEM; j++) mem[j] = $urandom;
    endtask

    task automatic run_dump(input string tag, input int pct, input int pulse_at,
                            input int abort_at, input int hold);
        int beat, dones, last_hs, cyc;
        bit pulsed, seen_valid, aborted, pstall, finished;
        logic [CDW-1:0] p_data;
        logic [1:0]     p_kind;
        logic [IW-1:0]  p_index;
        logic           p_last;
        beat = 0; dones = 0; last_hs = 0; pulsed = 0; seen_valid = 0;
        aborted = 0; pstall = 0; finished = 0;
        p_data = '0; p_kind = '0; p_index = '0; p_last = 1'b0;
        for (int i = 0; i < NB; i++) begin g_data[i] = 'x; g_kind[i] = 'x; g_index[i] = -1; end
        build_model();
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b0;
        for (cyc = 1; cyc <= 20000; cyc++) begin
            @(negedge clk);
            start = (cyc < hold);
            if (pulse_at >= 0 && !pulsed && beat == pulse_at && out_valid) begin
                start = 1'b1;
                pulsed = 1'b1;
            end
            if (cyc == 1) chk({tag, " busy after start"}, 64'(busy), 64'd1);
            if (!seen_valid && out_valid) begin
                seen_valid = 1'b1;
                chk({tag, " first valid latency"}, 64'(cyc), 64'd3);
            end
            if (done) begin
                dones++;
                chk({tag, " done after final handshake"}, 64'(cyc), 64'(last_hs + 1));
                chk({tag, " beats before done"}, 64'(beat), 64'(NB));
            end
            if (pstall) begin
                chk($sformatf("%s stall valid b%0d", tag, beat), 64'(out_valid), 64'd1);
                chk($sformatf("%s stall data b%0d", tag, beat), 64'(out_data), 64'(p_data));
                chk($sformatf("%s stall kind b%0d", tag, beat), 64'(out_kind), 64'(p_kind));
                chk($sformatf("%s stall index b%0d", tag, beat), 64'(out_index), 64'(p_index));
                chk($sformatf("%s stall last b%0d", tag, beat), 64'(out_last), 64'(p_last));
            end
            if (abort_at >= 0 && beat == abort_at && out_valid) begin
                rst = 1'b0;
                out_ready = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (dones > 0 && !busy) begin
                finished = 1'b1;
                break;
            end
            out_ready = ($urandom_range(99) < pct);
            pstall = out_valid && !out_ready;
            p_data = out_data; p_kind = out_kind; p_index = out_index; p_last = out_last;
            if (out_valid && out_ready) begin
                if (beat < NB) begin
                    chk($sformatf("%s data b%0d", tag, beat), 64'(out_data), 64'(e_data[beat]));
                    chk($sformatf("%s kind b%0d", tag, beat), 64'(out_kind), 64'(e_kind[beat]));
                    chk($sformatf("%s index b%0d", tag, beat), 64'(out_index), 64'(e_index[beat]));
                    chk($sformatf("%s last b%0d", tag, beat), 64'(out_last), 64'(e_last[beat]));
                    g_data[beat] = out_data; g_kind[beat] = out_kind; g_index[beat] = int'(out_index);
                    if (pct >= 100 && beat > 0 && beat < NREG + NMEM)
                        chk($sformatf("%s beat spacing b%0d", tag, beat), 64'(cyc - last_hs), 64'd3);
                end else begin
                    chk({tag, " beat count bound"}, 64'(beat), 64'(NB - 1));
                end
                beat++;
                last_hs = cyc;
            end
        end
        start = 1'b0;
        out_ready = 1'b0;
        if (aborted) begin
            @(negedge clk);
            chk({tag, " abort out_valid"}, 64'(out_valid), 64'd0);
            chk({tag, " abort busy"}, 64'(busy), 64'd0);
            chk({tag, " abort done"}, 64'(done), 64'd0);
            chk({tag, " abort out_data"}, 64'(out_data), 64'd0);
            chk({tag, " abort dones"}, 64'(dones), 64'd0);
            rst = 1'b1;
            @(negedge clk);
        end else begin
            chk({tag, " completed"}, 64'(finished), 64'd1);
            chk({tag, " done count"}, 64'(dones), 64'd1);
            chk({tag, " total beats"}, 64'(beat), 64'(NB));
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                if (done || busy) begin
                    chk({tag, " quiet after dump"}, 64'({done, busy}), 64'd0);
                    break;
                end
            end
        end
    endtask

    initial begin
        randomize_state();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset out_last", 64'(out_last), 64'd0);
        chk("reset mem_rd_en", 64'(mem_rd_en), 64'd0);
        chk("reset out_data", 64'(out_data), 64'd0);
        chk("reset out_index", 64'(out_index), 64'd0);
        chk("reset out_kind", 64'(out_kind), 64'd0);
        chk("reset addrs", 64'({rf_rd_addr, mem_rd_addr}), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Known markers in otherwise random state, sink always ready.
        regs[5] = 32'hDEADBEEF;
        mem[10] = 32'h12345678;
        run_dump("t1", 100, -1, -1, 1);
        chk("t1 beat5 data", 64'(g_data[5]), 64'h0DEADBEEF);
        chk("t1 beat5 kind", 64'(g_kind[5]), 64'd0);
        chk("t1 beat5 index", 64'(g_index[5]), 64'd5);
        chk("t1 beat42 data", 64'(g_data[42]), 64'h012345678);
        chk("t1 beat42 kind", 64'(g_kind[42]), 64'd1);
        chk("t1 beat42 index", 64'(g_index[42]), 64'd10);

        // Same contents under heavy back-pressure.
        run_dump("t2", 30, -1, -1, 1);

        // Stray start mid-dump, with fresh contents.
        randomize_state();
        run_dump("t3", 100, 20, -1, 1);

        // Reset during beat 40, then a clean restart.
        run_dump("t4a", 100, -1, 40, 1);
        run_dump("t4b", 100, -1, -1, 1);
        chk("t4b restart kind", 64'(g_kind[0]), 64'd0);
        chk("t4b restart index", 64'(g_index[0]), 64'd0);

        // Checksum-friendly contents.
        for (int i = 0; i < NREG; i++) regs[i] = i;
        for (int j = 0; j < NMEM; j++) mem[j] = 32'd1;
        run_dump("t5", 70, -1, -1, 1);
`ifdef DUMP_CHECKSUM_EN
        chk("t5 checksum data", 64'(g_data[NB-1]), 64'h230);
        chk("t5 checksum kind", 64'(g_kind[NB-1]), 64'd2);
`else
        chk("t5 final kind", 64'(g_kind[NB-1]), 64'd1);
        chk("t5 final index", 64'(g_index[NB-1]), 64'd63);
`endif

        // Start held high for five cycles.
        randomize_state();
        run_dump("t6", 100, -1, -1, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
